// File: rtl/comb_sweep_controller.sv
// Sweep engine: drives every input vector onto a combinational unit and holds each for SETTLE cycles.
// It assembles the observed truth table and compares it with a latched expected pattern.
// Optional macro SEQ_ABORT_ON_FAIL_EN stops the sweep at the first mismatching sample.
module comb_sweep_controller #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [(1<<N_IN)-1:0] truth_table,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int NV = 1 << N_IN;
  localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN:0]   ONE      = (N_IN+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [N_IN-1:0] idx, idx_nx;
  logic [7:0]      cnt, cnt_nx;
  logic [NV-1:0]   exp_lat, exp_nx;
  logic [NV-1:0]   table_nx;
  logic            pass_nx;
  logic [N_IN:0]   mism_nx;
  logic [N_IN-1:0] fail_nx;
  logic [NV-1:0]   diff;
  logic [N_IN:0]   pop;
  logic [N_IN-1:0] low;
  logic            found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      exp_lat      <= '0;
      truth_table  <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      cnt          <= cnt_nx;
      exp_lat      <= exp_nx;
      truth_table  <= table_nx;
      pass         <= pass_nx;
      mismatch_cnt <= mism_nx;
      fail_idx     <= fail_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    exp_nx   = exp_lat;
    table_nx = truth_table;
    pass_nx  = pass;
    mism_nx  = mismatch_cnt;
    fail_nx  = fail_idx;
    diff     = '0;
    pop      = '0;
    low      = '0;
    found    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          exp_nx   = expected;
          table_nx = '0;
          idx_nx   = '0;
          cnt_nx   = '0;
          pass_nx  = 1'b0;
          mism_nx  = '0;
          fail_nx  = '0;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          table_nx[idx] = dut_y;
`ifdef SEQ_ABORT_ON_FAIL_EN
          if (dut_y != exp_lat[idx]) begin
            state_nx = DONE;
            pass_nx  = 1'b0;
            mism_nx  = ONE;
            fail_nx  = idx;
          end else
`endif
          if (idx == IDX_LAST) begin
            // results use table_nx so the sample taken on this edge is included
            state_nx = DONE;
            diff     = table_nx ^ exp_lat;
            for (int unsigned i = 0; i < NV; i++) begin
              if (diff[i]) begin
                pop = pop + ONE;
                if (!found) begin
                  found = 1'b1;
                  low   = N_IN'(i);
                end
              end
            end
            pass_nx = (pop == '0);
            mism_nx = pop;
            fail_nx = low;
          end else begin
            idx_nx = idx + 1'b1;
            cnt_nx = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign dut_in = (state == RUN) ? idx : '0;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule
